// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared op codes and FSM state encoding for the iterative divider.
//   EXE_DIV_OP / EXE_DIVU_OP : alucontrol codes that launch the divider
//   EXE_ADD_OP               : an ordinary ALU op, ignored by the divider
//   div_state_e              : divider FSM states
//   is_div_op()              : true for either divide code
package div_unit_pkg;

  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;
  localparam logic [7:0] EXE_ADD_OP  = 8'b00100000;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_BUSY = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring division step (pure combinational).
//   rem_i, quo_i : current partial remainder / quotient shift register
//   dvs_i        : divisor magnitude
//   rem_o, quo_o : {rem, quo} after shift-left-by-1 and trial subtract
module div_step #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rem_i,
  input  logic [DW-1:0] quo_i,
  input  logic [DW-1:0] dvs_i,
  output logic [DW-1:0] rem_o,
  output logic [DW-1:0] quo_o
);

  // The shifted remainder needs DW+1 bits: rem < dvs <= 2^DW-1, so after
  // the shift it can exceed DW bits before the subtract brings it back.
  logic [DW:0] sh_rem;
  logic [DW:0] diff;
  logic        borrow;
  logic        unused_diff_top;

  always_comb begin
    sh_rem          = {rem_i, quo_i[DW-1]};
    {borrow, diff}  = {1'b0, sh_rem} - {2'b00, dvs_i};
    // On no-borrow the difference is < dvs, so its top bit is always 0.
    unused_diff_top = diff[DW];
    rem_o           = borrow ? sh_rem[DW-1:0] : diff[DW-1:0];
    quo_o           = {quo_i[DW-2:0], ~borrow};
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative DIV/DIVU unit for the execute stage.
//   clk, rst    : pipeline clock, async active-high reset
//   alucontrol  : execute op code; only DIV/DIVU launch the unit
//   start       : execute stage holds a valid instruction
//   flush       : cancel in-flight or launching division
//   a, b        : dividend / divisor
//   stall_div   : hold IF..EX while a division is in flight
//   ready       : one-cycle pulse, result valid
//   result      : {hi = remainder, lo = quotient}
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      alucontrol,
  input  logic            start,
  input  logic            flush,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            stall_div,
  output logic            ready,
  output logic [2*DW-1:0] result
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  div_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sgn_q, sgn_d;     // signed op (DIV)
  logic            sa_q, sa_d;       // sign of a
  logic            sb_q, sb_d;       // sign of b
  logic [DW-1:0]   rem_q, rem_d;
  logic [DW-1:0]   quo_q, quo_d;
  logic [DW-1:0]   dvs_q, dvs_d;
  logic [2*DW-1:0] result_q, result_d;

  logic            launch;
  logic            op_sgn;
  logic [DW-1:0]   a_mag, b_mag;
  logic [DW-1:0]   step_rem, step_quo;
  logic [DW-1:0]   q_fix, r_fix;
  logic [DW-1:0]   a_raw;

  div_step #(.DW(DW)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    launch = start && !flush && is_div_op(alucontrol);
    op_sgn = (alucontrol == EXE_DIV_OP);
    a_mag  = (op_sgn && a[DW-1]) ? -a : a;
    b_mag  = (op_sgn && b[DW-1]) ? -b : b;

    // Sign fix-up on the final step output; modulo-2^DW negation makes
    // MIN / -1 come out as {hi=0, lo=MIN} with no special case.
    q_fix  = (sgn_q && (sa_q ^ sb_q)) ? -step_quo : step_quo;
    r_fix  = (sgn_q && sa_q)          ? -step_rem : step_rem;

    // quo_q still holds |a| in DIV_ZERO; rebuild the original dividend.
    a_raw  = (sgn_q && sa_q) ? -quo_q : quo_q;

    state_d  = state_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;

    case (state_q)
      DIV_IDLE: begin
        if (launch) begin
          sgn_d   = op_sgn;
          sa_d    = a[DW-1];
          sb_d    = b[DW-1];
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          cnt_d   = '0;
          state_d = (b == '0) ? DIV_ZERO : DIV_BUSY;
        end
      end
      DIV_ZERO: begin
        result_d = {a_raw, {DW{1'b1}}};
        state_d  = DIV_DONE;
      end
      DIV_BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == CW'(DW - 1)) begin
          result_d = {r_fix, q_fix};
          state_d  = DIV_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase

    // Flush abandons any division and leaves the last result untouched.
    if (flush && state_q != DIV_IDLE) begin
      state_d  = DIV_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
    end
  end

  // Stall covers the launch cycle itself, so it must see launch directly.
  assign stall_div = !flush && ((state_q == DIV_IDLE && launch) ||
                                state_q == DIV_ZERO || state_q == DIV_BUSY);
  assign ready     = (state_q == DIV_DONE) && !flush;
  assign result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit (DW = 32).
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      alucontrol;
  logic            start;
  logic            flush;
  logic [DW-1:0]   a_i, b_i;
  logic            stall_div;
  logic            ready;
  logic [2*DW-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*DW-1:0] sb_q[$];
  logic [2*DW-1:0] last_res;

  div_unit #(.DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .alucontrol (alucontrol),
    .start      (start),
    .flush      (flush),
    .a          (a_i),
    .b          (b_i),
    .stall_div  (stall_div),
    .ready      (ready),
    .result     (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2*DW-1:0] got, input logic [2*DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (sb_q.size() == 0) chk("spurious_ready", 64'(ready), 64'd0);
      else begin
        logic [2*DW-1:0] e;
        e = sb_q.pop_front();
        chk("result", result, e);
        last_res = e;
      end
    end
  end

  task automatic run_div(input logic [7:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int exp_lat);
    logic [2*DW-1:0] exp;
    logic [DW-1:0] am, bm, q, r;
    int cyc;
    logic sg;
    // Reference model
    sg = (op == EXE_DIV_OP);
    am = (sg && a[DW-1]) ? -a : a;
    bm = (sg && b[DW-1]) ? -b : b;
    if (b == 0) exp = {a, {DW{1'b1}}};
    else begin
      q = am / bm;
      r = am % bm;
      if (sg && (a[DW-1] ^ b[DW-1])) q = -q;
      if (sg && a[DW-1]) r = -r;
      exp = {r, q};
    end
    @(negedge clk);
    alucontrol = op; a_i = a; b_i = b; start = 1'b1;
    sb_q.push_back(exp);
    #1 chk("stall_launch", 64'(stall_div), 64'd1);
    @(negedge clk);
    // Scramble inputs: the unit must use its latched operands.
    start = 1'b0; alucontrol = EXE_ADD_OP; a_i = $urandom; b_i = $urandom;
    cyc = 1;
    while (ready !== 1'b1 && cyc < 100) begin
      chk("stall_busy", 64'(stall_div), 64'd1);
      @(negedge clk);
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(exp_lat));
    chk("stall_ready", 64'(stall_div), 64'd0);
    @(negedge clk);
    chk("ready_pulse", 64'(ready), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; alucontrol = '0; a_i = '0; b_i = '0;
    last_res = '0;
    repeat (2) @(negedge clk);
    chk("rst_stall", 64'(stall_div), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_result", result, 64'd0);
    rst = 1'b0;

    run_div(EXE_DIVU_OP, 32'd100, 32'd7, 33);
    chk("divu_100_7_const", last_res, {32'd2, 32'd14});
    run_div(EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, 33);
    chk("div_m7_2_const", last_res, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_div(EXE_DIV_OP, 32'd7, 32'hFFFFFFFE, 33);
    chk("div_7_m2_const", last_res, {32'd1, 32'hFFFFFFFD});
    run_div(EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF, 33);
    chk("div_min_m1_const", last_res, {32'd0, 32'h80000000});
    run_div(EXE_DIVU_OP, 32'h80000000, 32'hFFFFFFFF, 33);
    chk("divu_min_m1_const", last_res, {32'h80000000, 32'd0});
    run_div(EXE_DIVU_OP, 32'd5, 32'd0, 2);
    chk("divu_zero_const", last_res, {32'd5, 32'hFFFFFFFF});
    for (int i = 0; i < 4; i++)
      run_div((i % 2) ? EXE_DIV_OP : EXE_DIVU_OP, $urandom, $urandom_range(1, 1000) * (i + 1), 33);

    // Flush at BUSY cycle 10: no ready, result unchanged.
    @(negedge clk);
    alucontrol = EXE_DIVU_OP; a_i = 32'd1000; b_i = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_stall", 64'(stall_div), 64'd0);
    @(negedge clk); flush = 1'b0;
    #1 chk("flush_idle_stall", 64'(stall_div), 64'd0);
    chk("flush_result", result, last_res);
    repeat (40) begin
      @(negedge clk);
      chk("flush_no_ready", 64'(ready), 64'd0);
    end
    run_div(EXE_DIVU_OP, 32'd9, 32'd3, 33);
    chk("divu_9_3_const", last_res, {32'd0, 32'd3});

    // Async reset mid-BUSY.
    @(negedge clk);
    alucontrol = EXE_DIVU_OP; a_i = 32'd77; b_i = 32'd5; start = 1'b1;
    sb_q.push_back('0);
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("arst_stall", 64'(stall_div), 64'd0);
    chk("arst_ready", 64'(ready), 64'd0);
    chk("arst_result", result, 64'd0);
    void'(sb_q.pop_back());
    @(negedge clk); rst = 1'b0;

    // Non-divide op: no stall, no ready.
    alucontrol = EXE_ADD_OP; start = 1'b1; a_i = 32'd3; b_i = 32'd0;
    #1 chk("add_stall", 64'(stall_div), 64'd0);
    repeat (5) begin
      @(negedge clk);
      chk("add_stall_hold", 64'(stall_div), 64'd0);
      chk("add_no_ready", 64'(ready), 64'd0);
    end
    start = 1'b0;
    @(negedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
